// File: rtl/bbs_pkg.sv
// Shared types and constants for the BBS seed search block.
package bbs_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StIssue,
        StWait,
        StEval,
        StDone
    } bbs_state_e;

    // Smallest modulus and seed that can yield a useful BBS sequence
    localparam int unsigned MIN_MODULUS = 3;
    localparam int unsigned MIN_SEED    = 2;

endpackage

// File: rtl/bbs_seed_search_if.sv
// Operand/result handshake between the seed search sequencer and the shared GCD unit.
interface bbs_seed_search_if #(
    parameter int unsigned W = 16
) ();

    logic [W-1:0] gcd_a;
    logic [W-1:0] gcd_b;
    logic         gcd_val;
    logic         gcd_rdy;
    logic [W-1:0] gcd_result;
    logic         gcd_res_val;
    logic         gcd_res_rdy;

    modport master (
        output gcd_a,
        output gcd_b,
        output gcd_val,
        input  gcd_rdy,
        input  gcd_result,
        input  gcd_res_val,
        output gcd_res_rdy
    );

    modport slave (
        input  gcd_a,
        input  gcd_b,
        input  gcd_val,
        output gcd_rdy,
        output gcd_result,
        output gcd_res_val,
        input  gcd_res_rdy
    );

endinterface

// File: rtl/bbs_seed_search.sv
// Walks candidate seeds upward from seed_in, asking the shared GCD unit for gcd(m, cand),
// until a candidate coprime with m is found or MAX_TRIES evaluations are spent.
module bbs_seed_search
    import bbs_pkg::*;
#(
    parameter int unsigned W         = 16,
    parameter int unsigned MAX_TRIES = 16,
    localparam int unsigned TW       = $clog2(MAX_TRIES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [W-1:0]      seed_in,
    input  logic [W-1:0]      m_in,
    output logic              busy,
    output logic              done,
    output logic              seed_ok,
    output logic [W-1:0]      seed_out,
    output logic [TW-1:0]     tries,
    bbs_seed_search_if.master gcd
);

    bbs_state_e state_q, state_d;

    logic [W-1:0]  m_q, m_d;
    logic [W-1:0]  cand_q, cand_d;
    logic [W-1:0]  g_q, g_d;
    logic [W-1:0]  seed_out_q, seed_out_d;
    logic [TW-1:0] tries_q, tries_d;
    logic          seed_ok_q, seed_ok_d;

    logic [TW-1:0] tries_inc;
    logic          last_try;
    logic          bad_inputs;

    // tries_q < MAX_TRIES whenever EVAL is reached, so the increment never wraps
    assign tries_inc  = tries_q + 1'b1;
    assign last_try   = (32'(tries_inc) == MAX_TRIES);
    assign bad_inputs = (m_q < W'(MIN_MODULUS)) || (cand_q >= m_q);

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        cand_d     = cand_q;
        g_d        = g_q;
        seed_out_d = seed_out_q;
        tries_d    = tries_q;
        seed_ok_d  = seed_ok_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d       = m_in;
                    cand_d    = seed_in;
                    tries_d   = '0;
                    seed_ok_d = 1'b0;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                if (bad_inputs) begin
                    seed_ok_d  = 1'b0;
                    seed_out_d = cand_q;
                    tries_d    = '0;
                    state_d    = StDone;
                end else begin
                    // Seeds 0 and 1 are degenerate; bump to 2 without charging a try
                    if (cand_q < W'(MIN_SEED)) begin
                        cand_d = W'(MIN_SEED);
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (gcd.gcd_rdy) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (gcd.gcd_res_val) begin
                    g_d     = gcd.gcd_result;
                    state_d = StEval;
                end
            end
            StEval: begin
                tries_d    = tries_inc;
                seed_out_d = cand_q;
                if (g_q == W'(1)) begin
                    seed_ok_d = 1'b1;
                    state_d   = StDone;
                end else if (last_try) begin
                    seed_ok_d = 1'b0;
                    state_d   = StDone;
                end else begin
                    // cand_q < m_q <= 2^W - 1, so this cannot overflow
                    cand_d  = cand_q + 1'b1;
                    state_d = StIssue;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            m_q        <= '0;
            cand_q     <= '0;
            g_q        <= '0;
            seed_out_q <= '0;
            tries_q    <= '0;
            seed_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            cand_q     <= cand_d;
            g_q        <= g_d;
            seed_out_q <= seed_out_d;
            tries_q    <= tries_d;
            seed_ok_q  <= seed_ok_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign seed_ok  = seed_ok_q;
    assign seed_out = seed_out_q;
    assign tries    = tries_q;

    // Operands come straight from the registers, so they stay stable under backpressure
    assign gcd.gcd_a       = m_q;
    assign gcd.gcd_b       = cand_q;
    assign gcd.gcd_val     = (state_q == StIssue);
    assign gcd.gcd_res_rdy = (state_q == StWait);

endmodule

// File: doc/bbs_seed_search.md
Name: bbs_seed_search

Overview:
Sequences the shared GCD unit to find a valid Blum Blum Shub seed for modulus m. Starting from a candidate seed, it issues gcd(m, cand) and accepts the first candidate with gcd == 1. Otherwise it increments the candidate and retries, bounded by MAX_TRIES. It sits between the BBS generator's load logic and the gcdGCDUnit_rtl instance, and replaces the single-shot seed_val check.

Parameters:
W, 16, datapath width of seed, modulus and GCD operands.
MAX_TRIES, 16, maximum GCD evaluations per search (>= 1).

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  request a search; sampled only in IDLE.
seed_in  in  W  initial candidate seed.
m_in  in  W  modulus.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the search ends.
seed_ok  out  1  at done: 1 = seed_out is coprime with m.
seed_out  out  W  last evaluated (or accepted) candidate.
tries  out  $clog2(MAX_TRIES+1)  GCD evaluations completed in the last search.
gcd_a  out  W  GCD operand A (= m).
gcd_b  out  W  GCD operand B (= candidate).
gcd_val  out  1  operand valid.
gcd_rdy  in  1  GCD unit ready for operands.
gcd_result  in  W  GCD result.
gcd_res_val  in  1  result valid.
gcd_res_rdy  out  1  result accept.

Behaviour:
- Reset (async, reset_n = 0): state IDLE; busy, done, seed_ok, gcd_val, gcd_res_rdy = 0; seed_out, tries, gcd_a, gcd_b = 0. The GCD unit shares this reset, so no stale result survives.
- States: IDLE, CHECK, ISSUE, WAIT, EVAL, DONE.
- IDLE: if start, register m_in to m_r and seed_in to cand; clear tries; go to CHECK. start while busy is ignored.
- CHECK (1 cycle), in priority order:
  - m_r < 3, or cand >= m_r: seed_ok = 0, seed_out = cand, tries = 0; go to DONE. No GCD transaction occurs.
  - cand < 2: cand = 2, with no try counted; go to ISSUE.
  - otherwise: go to ISSUE.
- ISSUE: gcd_val = 1, gcd_a = m_r, gcd_b = cand. Operands are held stable while gcd_rdy = 0. The transfer happens on the cycle where gcd_val && gcd_rdy; then go to WAIT. gcd_val is low outside ISSUE.
- WAIT: gcd_res_rdy = 1 (low in every other state). On gcd_res_val, capture gcd_result into g_r; go to EVAL.
- EVAL: tries += 1 (saturating arithmetic is not needed, since tries <= MAX_TRIES); seed_out = cand.
  - g_r == 1: seed_ok = 1; go to DONE.
  - tries+1 == MAX_TRIES: seed_ok = 0; go to DONE.
  - otherwise: cand += 1; go to ISSUE.
- Termination: gcd(m, m-1) = 1, so a search reaching m-1 always succeeds. cand never reaches m, and no wrap logic is needed.
- DONE: done = 1 for exactly one cycle; go to IDLE. seed_ok, seed_out and tries hold until the next accepted start.
- Latency with a zero-wait GCD: start to done = 3 + per-try (ISSUE 1 + WAIT 1 + GCD latency + EVAL 1).
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. Any in-flight GCD operation is cleared by the shared reset.
- All comparisons are unsigned W-bit. cand + 1 cannot overflow, because cand < m_r <= 2^W - 1.

Decomposition:
- Shared package bbs_pkg:
  - state enum (IDLE, CHECK, ISSUE, WAIT, EVAL, DONE)
  - MIN_MODULUS = 3
  - MIN_SEED = 2
- Single module with no sub-modules. gcdGCDUnit_rtl is instantiated by the parent (bbs_top), not inside this block.

Test Plan:
1. m = 253, seed = 3, GCD model connected -> one GCD transaction (A = 253, B = 3); done with seed_ok = 1, seed_out = 3, tries = 1.
2. m = 6, seed = 3 -> gcd results 3, 2, 1 for B = 3, 4, 5; done with seed_ok = 1, seed_out = 5, tries = 3.
3. m = 253, seed = 0 -> first B = 2, tries not charged for the bump; seed_ok = 1, seed_out = 2, tries = 1.
4. Bad inputs:
   - m = 2, seed = 1 -> done two cycles after start, seed_ok = 0, tries = 0, gcd_val never asserted.
   - m = 10, seed = 12 -> same response.
5. MAX_TRIES = 2, m = 12, seed = 2 -> B = 2 (gcd 2), B = 3 (gcd 3); done with seed_ok = 0, seed_out = 3, tries = 2.
6. Backpressure and reset:
   - Hold gcd_rdy = 0 for 5 cycles in ISSUE -> gcd_val stays 1 with gcd_b stable, exactly one transfer.
   - Assert reset_n = 0 while in WAIT -> same-cycle return to IDLE. busy = 0, gcd_res_rdy = 0; done never pulses.
   - Start again after reset -> search completes normally.
